// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared types for the instruction sequencer.
//   pc_op_t     : 3-bit operation code presented by the control decoder
//   seq_state_t : sequencer FSM states
package cpu_pkg;

    typedef enum logic [2:0] {
        NEXT = 3'd0,
        JABS = 3'd1,
        JREL = 3'd2,
        CALL = 3'd3,
        RET  = 3'd4,
        HALT = 3'd5
    } pc_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Bundles the decoder-facing handshake and the sequencer status outputs.
//   master : control side, drives start/stall/op/cond/abs_target/rel_off
//   slave  : the sequencer, drives prog_ctr/running/done/ras_count/ras_err
// op is a plain 3-bit vector because codes 6 and 7 are legal on the wire.
interface pc_sequencer_if #(
    parameter int PC_W      = 10,
    parameter int REL_W     = 6,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic              start;
    logic              stall;
    logic [2:0]        op;
    logic              cond;
    logic [PC_W-1:0]   abs_target;
    logic [REL_W-1:0]  rel_off;
    logic [PC_W-1:0]   prog_ctr;
    logic              running;
    logic              done;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_err;

    modport master (
        output start, stall, op, cond, abs_target, rel_off,
        input  prog_ctr, running, done, ras_count, ras_err
    );

    modport slave (
        input  start, stall, op, cond, abs_target, rel_off,
        output prog_ctr, running, done, ras_count, ras_err
    );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack
// Parametrised LIFO holding return addresses.
//   clk, reset : clock, synchronous active-high reset (empties the stack)
//   push, din  : write din on top; ignored when full
//   pop        : drop the top entry; ignored when empty
//   clr        : synchronous clear to empty
//   dout       : current top-of-stack value (zero when empty)
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clr,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign wr_idx = IDX_W'(count_q);
    assign rd_idx = IDX_W'(count_q - CNT_W'(1));
    assign dout   = empty ? '0 : mem[rd_idx];

    // Occupancy counter. Overflowing pushes and underflowing pops are
    // silently dropped here; the sequencer decides whether that is an error.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Storage has no reset: entries above the count are never observed.
    always_ff @(posedge clk) begin
        if (!reset && !clr && push && !full) begin
            mem[wr_idx] <= din;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Registered instruction sequencer: start/done handshake, conditional
// absolute and relative jumps, call/return through ret_stack, stall, halt.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; overrides every other input
//   bus   : pc_sequencer_if.slave
//           in  start, stall, op, cond, abs_target, rel_off
//           out prog_ctr (ROM address), running, done, ras_count, ras_err
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W       = 10,
    parameter int REL_W      = 6,
    parameter int RAS_DEPTH  = 4,
    parameter int START_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset,
    pc_sequencer_if.slave   bus
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    seq_state_t       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pc_inc, pc_rel;
    logic             err_q, err_d;
    logic             running_q, done_q;

    logic             stk_push, stk_pop, stk_clr;
    logic             stk_full, stk_empty;
    logic [PC_W-1:0]  stk_dout;
    logic [CNT_W-1:0] stk_count;

    // Both naturally wrap modulo 2^PC_W; the size cast sign-extends rel_off.
    assign pc_inc = pc_q + PC_W'(1);
    assign pc_rel = pc_q + PC_W'($signed(bus.rel_off));

    ret_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .clr   (stk_clr),
        .din   (pc_inc),
        .dout  (stk_dout),
        .count (stk_count),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Next-state and next-pc selection. A stalled RUN cycle falls through to
    // the defaults, so the pc, the error flag and the stack all hold.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_clr  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = PC_W'(START_ADDR);
                    err_d   = 1'b0;
                    stk_clr = 1'b1;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    case (pc_op_t'(bus.op))
                        JABS: pc_d = bus.cond ? bus.abs_target : pc_inc;
                        JREL: pc_d = bus.cond ? pc_rel : pc_inc;
                        CALL: begin
                            pc_d = bus.abs_target;
                            if (stk_full) begin
                                err_d = 1'b1;
                            end else begin
                                stk_push = 1'b1;
                            end
                        end
                        RET: begin
                            if (stk_empty) begin
                                pc_d  = pc_inc;
                                err_d = 1'b1;
                            end else begin
                                pc_d    = stk_dout;
                                stk_pop = 1'b1;
                            end
                        end
                        HALT: state_d = DONE;
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers. running/done are flopped from the next
    // state so they move on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            err_q     <= err_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    assign bus.prog_ctr  = pc_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.ras_count = stk_count;
    assign bus.ras_err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: directed scenarios followed by a
// randomized phase, every cycle compared against a queue-based model.
module tb_pc_sequencer;
    localparam int PC_W       = 10;
    localparam int REL_W      = 6;
    localparam int RAS_DEPTH  = 4;
    localparam int START_ADDR = 0;
    localparam int PC_MOD     = 1 << PC_W;

    logic clk;
    logic reset;

    int checks;
    int failures;

    // Reference model: 0 = idle, 1 = running, 2 = done.
    int m_mode;
    int m_pc;
    int m_stack[$];
    bit m_err;

    pc_sequencer_if #(.PC_W(PC_W), .REL_W(REL_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

    pc_sequencer #(
        .PC_W       (PC_W),
        .REL_W      (REL_W),
        .RAS_DEPTH  (RAS_DEPTH),
        .START_ADDR (START_ADDR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Behavioural model of one rising edge.
    task automatic modelStep(input bit r, input bit s, input bit st, input int o,
                             input bit c, input int abs_t, input int rel);
        int rel_s;
        rel_s = (rel >= (1 << (REL_W - 1))) ? rel - (1 << REL_W) : rel;
        if (r) begin
            m_mode = 0;
            m_pc   = 0;
            m_stack.delete();
            m_err  = 0;
        end else if (m_mode != 1) begin
            if (s) begin
                m_mode = 1;
                m_pc   = START_ADDR;
                m_stack.delete();
                m_err  = 0;
            end
        end else if (!st) begin
            case (o)
                1: m_pc = c ? abs_t : (m_pc + 1) % PC_MOD;
                2: m_pc = c ? (((m_pc + rel_s) % PC_MOD) + PC_MOD) % PC_MOD
                            : (m_pc + 1) % PC_MOD;
                3: begin
                    if (m_stack.size() == RAS_DEPTH) m_err = 1;
                    else m_stack.push_back((m_pc + 1) % PC_MOD);
                    m_pc = abs_t;
                end
                4: begin
                    if (m_stack.size() == 0) begin
                        m_err = 1;
                        m_pc  = (m_pc + 1) % PC_MOD;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
                end
                5: m_mode = 2;
                default: m_pc = (m_pc + 1) % PC_MOD;
            endcase
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then compare
    // every output a little after the edge.
    task automatic applyStimulus(input bit r, input bit s, input bit st, input int o,
                                 input bit c, input int abs_t, input int rel);
        reset          = r;
        bus.start      = s;
        bus.stall      = st;
        bus.op         = 3'(o);
        bus.cond       = c;
        bus.abs_target = PC_W'(abs_t);
        bus.rel_off    = REL_W'(rel);
        @(posedge clk);
        modelStep(r, s, st, o, c, abs_t, rel);
        #2;
        checkOutput("prog_ctr",  int'(bus.prog_ctr),  m_pc);
        checkOutput("running",   int'(bus.running),   int'(m_mode == 1));
        checkOutput("done",      int'(bus.done),      int'(m_mode == 2));
        checkOutput("ras_count", int'(bus.ras_count), m_stack.size());
        checkOutput("ras_err",   int'(bus.ras_err),   int'(m_err));
    endtask

    task automatic applyOp(input int o, input bit c, input int abs_t, input int rel);
        applyStimulus(1'b0, 1'b0, 1'b0, o, c, abs_t, rel);
    endtask

    task automatic doStart();
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
    endtask

    initial begin
        int o;
        checks   = 0;
        failures = 0;
        m_mode   = 0;
        m_pc     = 0;
        m_err    = 0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3, 1'b1, 77, 0);
        checkOutput("reset_pc", int'(bus.prog_ctr), 0);
        checkOutput("reset_running", int'(bus.running), 0);

        // Straight-line run and halt
        doStart();
        checkOutput("start_pc", int'(bus.prog_ctr), START_ADDR);
        applyOp(0, 1'b0, 0, 0);
        applyOp(0, 1'b0, 0, 0);
        applyOp(0, 1'b0, 0, 0);
        applyOp(5, 1'b0, 0, 0);
        checkOutput("halt_done", int'(bus.done), 1);
        checkOutput("halt_pc", int'(bus.prog_ctr), 3);
        applyOp(0, 1'b0, 0, 0);
        checkOutput("done_hold_pc", int'(bus.prog_ctr), 3);

        // Conditional jumps
        doStart();
        for (int i = 0; i < 5; i++) applyOp(0, 1'b0, 0, 0);
        applyOp(2, 1'b1, 0, 61);
        checkOutput("jrel_back", int'(bus.prog_ctr), 2);
        applyOp(2, 1'b1, 0, 61);
        checkOutput("jrel_wrap", int'(bus.prog_ctr), 1023);
        applyOp(1, 1'b0, 100, 0);
        checkOutput("jabs_not_taken", int'(bus.prog_ctr), 0);
        applyOp(2, 1'b0, 0, 5);
        checkOutput("jrel_not_taken", int'(bus.prog_ctr), 1);
        applyOp(5, 1'b0, 0, 0);

        // Nested calls
        doStart();
        applyOp(1, 1'b1, 10, 0);
        applyOp(3, 1'b0, 50, 0);
        applyOp(3, 1'b0, 80, 0);
        checkOutput("nest_count", int'(bus.ras_count), 2);
        applyOp(4, 1'b0, 0, 0);
        checkOutput("ret_inner", int'(bus.prog_ctr), 51);
        applyOp(4, 1'b0, 0, 0);
        checkOutput("ret_outer", int'(bus.prog_ctr), 11);
        checkOutput("nest_err", int'(bus.ras_err), 0);
        applyOp(5, 1'b0, 0, 0);

        // Overflow then underflow
        doStart();
        for (int i = 0; i < 5; i++) applyOp(3, 1'b0, 20 + i, 0);
        checkOutput("ovf_pc", int'(bus.prog_ctr), 24);
        checkOutput("ovf_count", int'(bus.ras_count), 4);
        checkOutput("ovf_err", int'(bus.ras_err), 1);
        applyOp(5, 1'b0, 0, 0);
        doStart();
        checkOutput("restart_err", int'(bus.ras_err), 0);
        applyOp(1, 1'b1, 7, 0);
        applyOp(4, 1'b0, 0, 0);
        checkOutput("unf_pc", int'(bus.prog_ctr), 8);
        checkOutput("unf_err", int'(bus.ras_err), 1);

        // Stall during a CALL
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 3, 1'b0, 200, 0);
            checkOutput("stall_pc", int'(bus.prog_ctr), 8);
            checkOutput("stall_count", int'(bus.ras_count), 0);
        end
        applyOp(3, 1'b0, 200, 0);
        checkOutput("call_commit_pc", int'(bus.prog_ctr), 200);
        checkOutput("call_commit_count", int'(bus.ras_count), 1);
        applyOp(3, 1'b0, 300, 0);

        // Reset mid-run, start in RUN, start in DONE
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
        checkOutput("midreset_pc", int'(bus.prog_ctr), 0);
        checkOutput("midreset_count", int'(bus.ras_count), 0);
        checkOutput("midreset_running", int'(bus.running), 0);
        doStart();
        applyOp(0, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 0);
        checkOutput("start_in_run", int'(bus.prog_ctr), 2);
        applyOp(5, 1'b0, 0, 0);
        doStart();
        checkOutput("restart_pc", int'(bus.prog_ctr), START_ADDR);
        checkOutput("restart_done", int'(bus.done), 0);

        // Randomized phase, HALT kept rare so programs run for a while
        for (int n = 0; n < 3000; n++) begin
            o = int'($urandom_range(0, 7));
            if (o == 5 && $urandom_range(0, 3) != 0) o = 0;
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 5) == 0,
                          o,
                          1'($urandom_range(0, 1)),
                          int'($urandom_range(0, PC_MOD - 1)),
                          int'($urandom_range(0, (1 << REL_W) - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised successor to the single-cycle program counter: a registered instruction sequencer with start/done handshake, conditional absolute and relative jumps, call/return through an internal return-address stack, stall, and halt. It sits between the control decoder and the instruction ROM. Its `prog_ctr` output drives the instruction ROM address, and `done` drives the core's top-level `done` output.

## Interface
- `PC_W`, default 10: program-counter width; the instruction ROM holds 2^PC_W words.
- `REL_W`, default 6: width of the signed relative offset.
- `RAS_DEPTH`, default 4: return-address stack entries, minimum 1.
- `START_ADDR`, default 0: address loaded on `start`.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin execution; sampled in IDLE or DONE.
- `stall` in 1: holds all state for this cycle.
- `op` in 3: `pc_op_t` operation for the instruction at `prog_ctr`.
- `cond` in 1: branch condition from the ALU flags.
- `abs_target` in PC_W: absolute target from the LUT, used by JABS and CALL.
- `rel_off` in REL_W: signed offset, two's complement.
- `prog_ctr` out PC_W: current instruction address, registered.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.
- `ras_count` out $clog2(RAS_DEPTH+1): stack occupancy.
- `ras_err` out 1: sticky flag for stack overflow or underflow.

## Operation
States: IDLE, RUN, DONE.
- Reset sets state=IDLE, `prog_ctr`=0, `done`=0, `running`=0, the stack to empty, `ras_count`=0, and `ras_err`=0. Reset wins over every other input.
- In IDLE or DONE, `start`=1 sets state=RUN, `prog_ctr`=START_ADDR, the stack to empty, and `ras_err`=0. `op` is ignored.
- In RUN, `start` is ignored.
- In RUN with `stall`=1, nothing changes, including the stack.
- In RUN with `stall`=0, the next `prog_ctr` depends on `op`:
  - NEXT: pc+1.
  - JABS: `abs_target` if `cond`, else pc+1.
  - JREL: pc + sign-extended `rel_off` if `cond`, else pc+1.
  - CALL: unconditional. Push pc+1 and go to `abs_target`.
  - RET: unconditional. Pop and go to the popped value.
  - HALT: `prog_ctr` holds and state=DONE.
  - Codes 6 and 7 behave as NEXT.
- Arithmetic is modulo 2^PC_W. pc+1 at 2^PC_W−1 wraps to 0. A relative jump below 0 or above the maximum wraps.
- CALL with a full stack still jumps. The push is discarded, the stack contents are unchanged, and `ras_err` is set.
- RET with an empty stack acts as NEXT and sets `ras_err`.
- `ras_err` stays set until reset or `start`.
- In DONE, `prog_ctr` holds the HALT address. A new `start` restarts execution.

## Timing
- Every output is registered. An `op` sampled at edge N produces the new `prog_ctr` after edge N, so each instruction takes 1 cycle.
- The ROM is combinational on `prog_ctr`, so `op`, `cond`, and the targets are valid in the same cycle.
- `done` and `running` change on the same edge as the state.
- `done` rises on the edge that samples HALT and stays high until `reset` or `start`.
- The stack push or pop and the `ras_count` update commit on the same edge as the `prog_ctr` update.
- `ras_count` never exceeds RAS_DEPTH and never goes below 0.

## Structure
- Shared package `cpu_pkg` holds:
  - `pc_op_t`, a 3-bit enum: NEXT=0, JABS=1, JREL=2, CALL=3, RET=4, HALT=5.
  - `seq_state_t`: IDLE, RUN, DONE.
- One sub-module, `ret_stack`: a parametrised LIFO with DEPTH and W parameters.
  - Inputs: `push`, `pop`, `din`, `clr`.
  - Outputs: `dout` (top of stack), `count`, `full`, `empty`.
  - Push when full and pop when empty are no-ops inside the stack. Error flagging lives in `pc_sequencer`.
- The next-pc mux and the FSM live in `pc_sequencer`.

## Test plan
1. Straight-line run and halt, START_ADDR=0: reset, pulse `start`, then NEXT ×3 and HALT. `prog_ctr` steps 0,1,2,3. `done` rises on the HALT edge and `prog_ctr` holds 3.
2. Conditional jumps:
   - At pc=5, JREL with `rel_off`=−3 and `cond`=1 gives 2.
   - At pc=2, JREL with `rel_off`=−3 and `cond`=1 wraps to 1023.
   - JABS with `abs_target`=100 and `cond`=0 gives pc+1.
3. Nested calls with RAS_DEPTH=4:
   - CALL to 50 from pc=10, then CALL to 80 from pc=50. `ras_count` is 2.
   - RET gives 51, then a second RET gives 11. `ras_count` returns to 0 and `ras_err`=0.
4. Stack overflow and underflow:
   - Five CALLs: the fifth still jumps, `ras_count` stays 4, `ras_err`=1.
   - After restart, RET on an empty stack at pc=7 gives 8 and sets `ras_err`.
5. Stall: assert `stall` for 3 cycles during a CALL. `prog_ctr` and `ras_count` stay frozen, and the CALL commits on the first unstalled edge.
6. Reset and start edge cases:
   - Assert `reset` mid-run with `ras_count`=2: next cycle `prog_ctr`=0, state IDLE, `ras_count`=0.
   - `start` during RUN is ignored.
   - `start` in DONE restarts at START_ADDR.
